// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Radix-2 datapath: shift-add multiply and restoring divide, one bit per
// cycle, with sign fix-up in a final cycle before HI/LO are written.
// Optional feature macro: MDU_DIV0_FLAG_EN adds a div0 output and a
// one-cycle fast path for divide-by-zero.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
`ifdef MDU_DIV0_FLAG_EN
  output logic             div0,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;    // product upper half / partial remainder
  logic [WIDTH-1:0]   a_q, a_d;        // multiplier (shifts out) / dividend->quotient
  logic [WIDTH-1:0]   b_q, b_d;        // multiplicand / divisor magnitude
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;    // negate product / quotient
  logic               rneg_q, rneg_d;  // negate remainder (dividend sign)
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
`ifdef MDU_DIV0_FLAG_EN
  logic               dz_q, dz_d;      // FIX entered via the divide-by-zero shortcut
  logic               div0_q, div0_d;
`endif

  logic               is_signed;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH-1:0]   div_rem;
  logic               div_ok;
  logic [2*WIDTH-1:0] product, product_neg;

  assign is_signed   = ~op[0];
  assign rs_mag      = (is_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign rt_mag      = (is_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
  assign mul_sum     = {1'b0, acc_q} + {1'b0, b_q};
  assign div_sh      = {acc_q, a_q[WIDTH-1]};
  assign div_ok      = div_sh >= {1'b0, b_q};
  assign div_rem     = WIDTH'(div_sh - {1'b0, b_q});
  assign product     = {acc_q, a_q};
  assign product_neg = -product;

  // Next-state, datapath iteration and HI/LO update
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MDU_DIV0_FLAG_EN
    dz_d     = dz_q;
    div0_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          // start has priority; concurrent MTHI/MTLO are dropped
          state_d  = CALC;
          cnt_d    = '0;
          acc_d    = '0;
          is_div_d = op[1];
          neg_d    = is_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
          rneg_d   = is_signed & rs_data[WIDTH-1];
          if (op[1]) begin
            a_d = rs_mag;
            b_d = rt_mag;
          end else begin
            a_d = rt_mag;
            b_d = rs_mag;
          end
`ifdef MDU_DIV0_FLAG_EN
          dz_d = 1'b0;
          if (op[1] && rt_data == '0) begin
            state_d = FIX;
            a_d     = rs_data;
            dz_d    = 1'b1;
          end
`endif
        end else begin
          if (hi_wr) hi_d = wr_data;
          if (lo_wr) lo_d = wr_data;
        end
      end
      CALC: begin
        if (is_div_q) begin
          acc_d = div_ok ? div_rem : div_sh[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], div_ok};
        end else if (a_q[0]) begin
          {acc_d, a_d} = {mul_sum, a_q[WIDTH-1:1]};
        end else begin
          {acc_d, a_d} = {1'b0, acc_q, a_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d = neg_q  ? -a_q   : a_q;
          hi_d = rneg_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = neg_q ? product_neg : product;
        end
`ifdef MDU_DIV0_FLAG_EN
        if (dz_q) begin
          hi_d   = a_q;
          lo_d   = '1;
          div0_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
      dz_q     <= 1'b0;
      div0_q   <= 1'b0;
`endif
    end else begin
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MDU_DIV0_FLAG_EN
      dz_q     <= dz_d;
      div0_q   <= div0_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MDU_DIV0_FLAG_EN
  assign div0 = div0_q;
`endif

endmodule
